// File: rtl/reg_writeback_queue_if.sv
// Writeback bus: ALU and long-latency result inputs, register file write
// outputs, scoreboard and FIFO occupancy.
interface reg_writeback_queue_if #(
  parameter int DEPTH = 4
);
  logic                     AluValid_i;
  logic [4:0]               AluRd_i;
  logic [31:0]              AluData_i;
  logic                     AluStall_o;
  logic                     LongIssue_i;
  logic [4:0]               LongIssueRd_i;
  logic                     LongValid_i;
  logic [4:0]               LongRd_i;
  logic [31:0]              LongData_i;
  logic                     LongReady_o;
  logic                     RegWrite_o;
  logic [4:0]               WriteRegister_o;
  logic [31:0]              WriteData_o;
  logic [31:0]              Pending_o;
  logic [$clog2(DEPTH):0]   Count_o;

  modport master (
    output AluValid_i, AluRd_i, AluData_i, LongIssue_i, LongIssueRd_i,
           LongValid_i, LongRd_i, LongData_i,
    input  AluStall_o, LongReady_o, RegWrite_o, WriteRegister_o,
           WriteData_o, Pending_o, Count_o
  );

  modport slave (
    input  AluValid_i, AluRd_i, AluData_i, LongIssue_i, LongIssueRd_i,
           LongValid_i, LongRd_i, LongData_i,
    output AluStall_o, LongReady_o, RegWrite_o, WriteRegister_o,
           WriteData_o, Pending_o, Count_o
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register file write-port owner: merges ALU results with FIFO-queued long results,
// tracks pending long writes. Define WB_BYPASS_EN to let long results skip an idle FIFO.
module reg_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  reg_writeback_queue_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic [31:0]   pending;
  logic          regWrite;
  logic [4:0]    writeRegister;
  logic [31:0]   writeData;

  logic          nonEmpty, longReady, accept, bypass, pushFifo, forced, pop;
  logic [31:0]   setMask, clrMask;

  assign head      = fifo[rdPtr];
  assign nonEmpty  = (count != '0);
  // count never exceeds DEPTH (a power of two), so its MSB alone marks full
  assign longReady = ~count[AW];
  assign accept    = wb.LongValid_i && longReady;
  assign forced    = nonEmpty && (starve == SW'(STARVE_MAX));
  assign pop       = forced || (!wb.AluValid_i && nonEmpty);

`ifdef WB_BYPASS_EN
  assign bypass    = accept && !nonEmpty && !wb.AluValid_i;
`else
  assign bypass    = 1'b0;
`endif
  assign pushFifo  = accept && !bypass;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (pop)    clrMask[head.rd]     = 1'b1;
    if (bypass) clrMask[wb.LongRd_i] = 1'b1;
    if (wb.LongIssue_i && (wb.LongIssueRd_i != 5'd0))
      setMask[wb.LongIssueRd_i] = 1'b1;
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (pushFifo) fifo[wrPtr] <= '{rd: wb.LongRd_i, data: wb.LongData_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
      starve        <= '0;
      pending       <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      if (pushFifo) wrPtr <= wrPtr + AW'(1);
      if (pop)      rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(pushFifo) - (AW+1)'(pop);

      if (pop || !nonEmpty)
        starve <= '0;
      else if (starve != SW'(STARVE_MAX))
        starve <= starve + SW'(1);

      // set wins over a same-cycle clear of the same bit
      pending <= (pending & ~clrMask) | setMask;

      if (pop) begin
        regWrite      <= (head.rd != 5'd0);
        writeRegister <= head.rd;
        writeData     <= head.data;
      end else if (wb.AluValid_i) begin
        regWrite      <= (wb.AluRd_i != 5'd0);
        writeRegister <= wb.AluRd_i;
        writeData     <= wb.AluData_i;
      end else if (bypass) begin
        regWrite      <= (wb.LongRd_i != 5'd0);
        writeRegister <= wb.LongRd_i;
        writeData     <= wb.LongData_i;
      end else begin
        regWrite      <= 1'b0;
      end
    end
  end

  assign wb.AluStall_o      = forced;
  assign wb.LongReady_o     = longReady;
  assign wb.RegWrite_o      = regWrite;
  assign wb.WriteRegister_o = writeRegister;
  assign wb.WriteData_o     = writeData;
  assign wb.Pending_o       = pending;
  assign wb.Count_o         = count;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DEPTH=4, STARVE_MAX=3).
module tb_reg_writeback_queue;
  logic clk_i = 1'b0;
  logic rst_i;
  int   nAssert = 0;
  int   nFail   = 0;

  reg_writeback_queue_if #(.DEPTH(4)) bus ();

  reg_writeback_queue #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] expPend;
    rst_i              = 1'b0;
    bus.AluValid_i     = 1'b0;
    bus.AluRd_i        = '0;
    bus.AluData_i      = '0;
    bus.LongIssue_i    = 1'b0;
    bus.LongIssueRd_i  = '0;
    bus.LongValid_i    = 1'b1;
    bus.LongRd_i       = 5'd3;
    bus.LongData_i     = 32'h3333;

    // reset held two edges with a long result offered
    tick(); tick();
    chk("rst_count", 32'(bus.Count_o), 0);
    chk("rst_pend", bus.Pending_o, 0);
    chk("rst_regwrite", 32'(bus.RegWrite_o), 0);
    chk("rst_wreg", 32'(bus.WriteRegister_o), 0);
    chk("rst_wdata", bus.WriteData_o, 0);
    bus.LongValid_i = 1'b0;
    rst_i = 1'b1;
    chk("rst_ready", 32'(bus.LongReady_o), 1);
    chk("rst_stall", 32'(bus.AluStall_o), 0);

    // ALU path
    bus.AluValid_i = 1'b1; bus.AluRd_i = 5'd5; bus.AluData_i = 32'h1234;
    tick();
    chk("alu_we", 32'(bus.RegWrite_o), 1);
    chk("alu_wreg", 32'(bus.WriteRegister_o), 5);
    chk("alu_wdata", bus.WriteData_o, 32'h1234);
    bus.AluRd_i = 5'd0; bus.AluData_i = 32'h55;
    tick();
    chk("alu_r0_we", 32'(bus.RegWrite_o), 0);
    bus.AluValid_i = 1'b0;
    tick();
    chk("idle_we", 32'(bus.RegWrite_o), 0);

    // long path
    bus.LongIssue_i = 1'b1; bus.LongIssueRd_i = 5'd9;
    tick();
    bus.LongIssue_i = 1'b0;
    chk("long_pend_set", bus.Pending_o, 32'h200);
    bus.LongValid_i = 1'b1; bus.LongRd_i = 5'd9; bus.LongData_i = 32'hDEAD_BEEF;
    chk("long_ready", 32'(bus.LongReady_o), 1);
    tick();
    bus.LongValid_i = 1'b0;
`ifdef WB_BYPASS_EN
    chk("byp_we", 32'(bus.RegWrite_o), 1);
    chk("byp_wreg", 32'(bus.WriteRegister_o), 9);
    chk("byp_wdata", bus.WriteData_o, 32'hDEAD_BEEF);
    chk("byp_pend", bus.Pending_o, 0);
    chk("byp_count", 32'(bus.Count_o), 0);
    tick();
    chk("byp_after_we", 32'(bus.RegWrite_o), 0);
`else
    chk("long_wait_we", 32'(bus.RegWrite_o), 0);
    chk("long_wait_count", 32'(bus.Count_o), 1);
    chk("long_wait_pend", bus.Pending_o, 32'h200);
    tick();
    chk("long_we", 32'(bus.RegWrite_o), 1);
    chk("long_wreg", 32'(bus.WriteRegister_o), 9);
    chk("long_wdata", bus.WriteData_o, 32'hDEAD_BEEF);
    chk("long_pend_clr", bus.Pending_o, 0);
    chk("long_count", 32'(bus.Count_o), 0);
`endif

    // fill with ALU held valid every cycle
    for (int i = 1; i <= 4; i++) begin
      bus.AluValid_i    = 1'b1;
      bus.AluRd_i       = 5'(20 + i);
      bus.AluData_i     = 32'hA00 + 32'(i);
      bus.LongValid_i   = 1'b1;
      bus.LongRd_i      = 5'(i);
      bus.LongData_i    = 32'h100 + 32'(i);
      bus.LongIssue_i   = 1'b1;
      bus.LongIssueRd_i = 5'(i);
      chk("fill_nostall", 32'(bus.AluStall_o), 0);
      tick();
      chk("fill_wreg", 32'(bus.WriteRegister_o), 32'(20 + i));
      chk("fill_count", 32'(bus.Count_o), 32'(i));
    end
    bus.LongIssue_i = 1'b0;
    chk("full_pend", bus.Pending_o, 32'h1E);
    chk("full_ready", 32'(bus.LongReady_o), 0);
    chk("full_stall", 32'(bus.AluStall_o), 1);
    bus.LongRd_i = 5'd5; bus.LongData_i = 32'h105;
    tick();
    bus.LongValid_i = 1'b0;
    chk("force1_wreg", 32'(bus.WriteRegister_o), 1);
    chk("force1_wdata", bus.WriteData_o, 32'h101);
    chk("force1_count", 32'(bus.Count_o), 3);
    chk("force1_pend", bus.Pending_o, 32'h1C);
    for (int k = 2; k <= 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        bus.AluRd_i   = 5'(24 + j);
        bus.AluData_i = 32'hB00 + 32'(k * 4 + j);
        chk("drain_nostall", 32'(bus.AluStall_o), 0);
        tick();
        chk("drain_alu_wreg", 32'(bus.WriteRegister_o), 32'(24 + j));
        chk("drain_alu_wdata", bus.WriteData_o, 32'hB00 + 32'(k * 4 + j));
      end
      chk("drain_stall", 32'(bus.AluStall_o), 1);
      tick();
      expPend = 32'h1E & ~((32'd1 << (k + 1)) - 32'd2);
      chk("drain_pop_wreg", 32'(bus.WriteRegister_o), 32'(k));
      chk("drain_pop_wdata", bus.WriteData_o, 32'h100 + 32'(k));
      chk("drain_pop_count", 32'(bus.Count_o), 32'(4 - k));
      chk("drain_pop_pend", bus.Pending_o, expPend);
    end
    bus.AluValid_i = 1'b0;
    tick();
    chk("drained_we", 32'(bus.RegWrite_o), 0);

    // pop of r7 with a same-cycle reissue of r7
    bus.AluValid_i = 1'b1; bus.AluRd_i = 5'd11; bus.AluData_i = 32'hC11;
    bus.LongValid_i = 1'b1; bus.LongRd_i = 5'd7; bus.LongData_i = 32'h707;
    bus.LongIssue_i = 1'b1; bus.LongIssueRd_i = 5'd7;
    tick();
    bus.AluValid_i = 1'b0; bus.LongValid_i = 1'b0;
    chk("r7_count", 32'(bus.Count_o), 1);
    tick();
    bus.LongIssue_i = 1'b0;
    chk("r7_wreg", 32'(bus.WriteRegister_o), 7);
    chk("r7_wdata", bus.WriteData_o, 32'h707);
    chk("r7_pend_kept", bus.Pending_o, 32'h80);

    // push and pop in one cycle at Count_o=2
    bus.AluValid_i = 1'b1; bus.AluRd_i = 5'd12; bus.AluData_i = 32'hC12;
    bus.LongValid_i = 1'b1; bus.LongRd_i = 5'd12; bus.LongData_i = 32'h1212;
    tick();
    bus.LongRd_i = 5'd13; bus.LongData_i = 32'h1313;
    tick();
    chk("pp_pre_count", 32'(bus.Count_o), 2);
    bus.AluValid_i = 1'b0;
    bus.LongRd_i = 5'd14; bus.LongData_i = 32'h1414;
    tick();
    chk("pp_count", 32'(bus.Count_o), 2);
    chk("pp_wreg", 32'(bus.WriteRegister_o), 12);
    chk("pp_wdata", bus.WriteData_o, 32'h1212);

    // mid-operation reset with three results queued
    bus.AluValid_i = 1'b1; bus.AluRd_i = 5'd15; bus.AluData_i = 32'hC15;
    bus.LongRd_i = 5'd15; bus.LongData_i = 32'h1515;
    tick();
    chk("mid_count", 32'(bus.Count_o), 3);
    bus.AluValid_i = 1'b0; bus.LongValid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("mid_rst_count", 32'(bus.Count_o), 0);
    chk("mid_rst_pend", bus.Pending_o, 0);
    chk("mid_rst_we", 32'(bus.RegWrite_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 32'(bus.RegWrite_o), 0);
      chk("post_rst_count", 32'(bus.Count_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
